// File: rtl/core_config_pkg.sv
// Shared core configuration: CSR address map, write masks and decode record.
package core_config_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CSR_ADDR_W = 12;

    typedef enum logic [CSR_ADDR_W-1:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MISA      = 12'h301,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MTVAL     = 12'h343,
        CSR_MIP       = 12'h344,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_CYCLE     = 12'hC00,
        CSR_INSTRET   = 12'hC02,
        CSR_CYCLEH    = 12'hC80,
        CSR_INSTRETH  = 12'hC82,
        CSR_MVENDORID = 12'hF11,
        CSR_MARCHID   = 12'hF12,
        CSR_MIMPID    = 12'hF13,
        CSR_MHARTID   = 12'hF14
    } csr_addr_t;

    localparam logic [XLEN-1:0] MSTATUS_WMASK = 32'h88;
    localparam logic [XLEN-1:0] MIE_WMASK     = 32'h888;
    localparam logic [1:0]      MSTATUS_MPP   = 2'b11;

    localparam int unsigned MSTATUS_MIE_IDX  = 3;
    localparam int unsigned MSTATUS_MPIE_IDX = 7;

    // Result of looking up one CSR address.
    typedef struct packed {
        logic            unimpl;
        logic [XLEN-1:0] val;
    } csr_rdec_t;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent half loads; a load wins over
// the increment for that cycle and the untouched half keeps its value.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        ld_lo,
    input  logic        ld_hi,
    input  logic [31:0] ld_data,
    output logic [63:0] count
);

    // Count register: reset, half load, or increment with natural wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (ld_lo || ld_hi) begin
            if (ld_lo) count[31:0]  <= ld_data;
            if (ld_hi) count[63:32] <= ld_data;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: trap CSRs, cycle/instret counters, ID registers,
// trap entry / mret sequencing and the registered interrupt-pending flag.
module csr_regfile
    import core_config_pkg::*;
#(
    parameter logic [XLEN-1:0] HART_ID  = 32'd0,
    parameter logic [XLEN-1:0] MISA_VAL = 32'h4000_0100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CSR_ADDR_W-1:0] csr_ra,
    output logic [XLEN-1:0]       csr_rd,
    input  logic [CSR_ADDR_W-1:0] csr_wa,
    input  logic                  csr_we,
    input  logic [XLEN-1:0]       csr_wd,
    output logic                  csr_err,
    input  logic                  retire,
    input  logic                  trap,
    input  logic [XLEN-1:0]       trap_cause,
    input  logic [XLEN-1:0]       trap_pc,
    input  logic [XLEN-1:0]       trap_val,
    input  logic                  mret,
    input  logic                  irq_sw,
    input  logic                  irq_timer,
    input  logic                  irq_ext,
    output logic [XLEN-1:0]       mtvec_o,
    output logic [XLEN-1:0]       mepc_o,
    output logic                  irq_pending
);

    logic [XLEN-1:0] mstatus_q;   // only MIE/MPIE bits are ever set
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [63:0]     cycle_cnt;
    logic [63:0]     instret_cnt;
    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] mip_val;
    csr_rdec_t       rdec;
    csr_rdec_t       wdec;
    logic            wa_ro;
    logic            wr_ok;

    assign mstatus_val = mstatus_q | {19'b0, MSTATUS_MPP, 11'b0};
    assign mip_val     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
    assign mtvec_o     = mtvec_q;
    assign mepc_o      = mepc_q;
    assign wr_ok       = csr_we && !csr_err;

    // Single address map shared by the read port and the write-legality check.
    function automatic csr_rdec_t csr_decode(input logic [CSR_ADDR_W-1:0] addr);
        csr_rdec_t r;
        r = '{unimpl: 1'b0, val: '0};
        unique case (addr)
            CSR_MSTATUS:                          r.val = mstatus_val;
            CSR_MISA:                             r.val = MISA_VAL;
            CSR_MIE:                              r.val = mie_q;
            CSR_MTVEC:                            r.val = mtvec_q;
            CSR_MSCRATCH:                         r.val = mscratch_q;
            CSR_MEPC:                             r.val = mepc_q;
            CSR_MCAUSE:                           r.val = mcause_q;
            CSR_MTVAL:                            r.val = mtval_q;
            CSR_MIP:                              r.val = mip_val;
            CSR_MCYCLE, CSR_CYCLE:                r.val = cycle_cnt[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:              r.val = cycle_cnt[63:32];
            CSR_MINSTRET, CSR_INSTRET:            r.val = instret_cnt[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:          r.val = instret_cnt[63:32];
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: r.val = '0;
            CSR_MHARTID:                          r.val = HART_ID;
            default:                              r.unimpl = 1'b1;
        endcase
        return r;
    endfunction

    // Read data and write legality; read-only space is [11:10]==2'b11 plus misa.
    always_comb begin
        rdec    = csr_decode(csr_ra);
        wdec    = csr_decode(csr_wa);
        csr_rd  = rdec.unimpl ? '0 : rdec.val;
        wa_ro   = (csr_wa[11:10] == 2'b11) || (csr_wa == CSR_MISA);
        csr_err = csr_we && (wdec.unimpl || (wa_ro && (csr_wd != wdec.val)));
    end

    // Trap/status state: trap beats mret beats CSR write on each register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q   <= '0;
            mie_q       <= '0;
            mtvec_q     <= '0;
            mscratch_q  <= '0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            irq_pending <= 1'b0;
        end else begin
            irq_pending <= mstatus_q[MSTATUS_MIE_IDX] && ((mip_val & mie_q) != '0);

            if (trap) begin
                mstatus_q[MSTATUS_MPIE_IDX] <= mstatus_q[MSTATUS_MIE_IDX];
                mstatus_q[MSTATUS_MIE_IDX]  <= 1'b0;
            end else if (mret) begin
                mstatus_q[MSTATUS_MIE_IDX]  <= mstatus_q[MSTATUS_MPIE_IDX];
                mstatus_q[MSTATUS_MPIE_IDX] <= 1'b1;
            end else if (wr_ok && csr_wa == CSR_MSTATUS) begin
                mstatus_q <= csr_wd & MSTATUS_WMASK;
            end

            if (trap) begin
                mepc_q   <= trap_pc & ~32'h3;
                mcause_q <= trap_cause;
                mtval_q  <= trap_val;
            end else if (wr_ok) begin
                if (csr_wa == CSR_MEPC)   mepc_q   <= csr_wd & ~32'h3;
                if (csr_wa == CSR_MCAUSE) mcause_q <= csr_wd;
                if (csr_wa == CSR_MTVAL)  mtval_q  <= csr_wd;
            end

            if (wr_ok && csr_wa == CSR_MIE)      mie_q      <= csr_wd & MIE_WMASK;
            if (wr_ok && csr_wa == CSR_MTVEC)    mtvec_q    <= csr_wd & ~32'h3;
            if (wr_ok && csr_wa == CSR_MSCRATCH) mscratch_q <= csr_wd;
        end
    end

    csr_counter64 u_cycle (
        .clk     (clk),
        .rst     (rst),
        .inc     (1'b1),
        .ld_lo   (wr_ok && (csr_wa == CSR_MCYCLE)),
        .ld_hi   (wr_ok && (csr_wa == CSR_MCYCLEH)),
        .ld_data (csr_wd),
        .count   (cycle_cnt)
    );

    csr_counter64 u_instret (
        .clk     (clk),
        .rst     (rst),
        .inc     (retire),
        .ld_lo   (wr_ok && (csr_wa == CSR_MINSTRET)),
        .ld_hi   (wr_ok && (csr_wa == CSR_MINSTRETH)),
        .ld_data (csr_wd),
        .count   (instret_cnt)
    );

endmodule
